bram_line_writer: RTL and testbench

Write-side controller for the camera line buffer built on the 1024 x 64 dual-port on-chip RAM. Accepts a stream of 16-bit pixels from the camera capture path and packs four pixels per 64-bit word. Writes each complete line into one of two 512-word ping-pong banks through RAM port 1, then hands the finished bank to the port-2 consumer with a ready/release handshake. Lines that arrive while no bank is free are dropped and flagged.

---
 rtl/bram_line_writer.sv | 200 ++++++++++++++++++++
 tb/tb_bram_line_writer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_line_writer.sv
// rtl/bram_line_writer.sv - packs a 16-bit pixel stream into 64-bit words and writes ping-pong line banks
//
// Purpose:
//   Takes 16-bit camera pixels, packs four per 64-bit word, and writes each line
//   into one of two 2^(ADDR_W-1)-word banks through RAM port 1. A finished bank
//   is announced with line_ready/line_bank and stays occupied until the consumer
//   returns it with rd_release/rd_bank. Lines that target an occupied bank are
//   dropped and flagged.
//
// Ports:
//   clk, reset           single clock, asynchronous active-high reset
//   enable               capture enable, sampled at each start of line
//   pix_valid, pix_sol   pixel qualifier and start-of-line marker
//   pix_data             16-bit RGB565 pixel
//   mem_address          RAM port-1 word address
//   mem_writedata        packed word, pixel k in bits [16k+15:16k]
//   mem_byteenable       8'hFF during a write, else 8'h00
//   mem_chipselect       follows mem_write
//   mem_write            one-cycle write strobe
//   line_ready           one-cycle pulse, line complete in bank line_bank
//   line_bank            bank of the most recently completed line
//   rd_release, rd_bank  consumer hands bank rd_bank back
//   bank_full            per-bank occupied flags
//   overflow             sticky, a line was dropped
//   short_line           sticky, a line was cut short by an early start of line
//   clear_flags          clears overflow and short_line

module bram_line_writer #(
   parameter int ADDR_W     = 10,
   parameter int LINE_WORDS = 160
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              pix_valid,
   input  logic              pix_sol,
   input  logic [15:0]       pix_data,
   output logic [ADDR_W-1:0] mem_address,
   output logic [63:0]       mem_writedata,
   output logic [7:0]        mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic              line_ready,
   output logic              line_bank,
   input  logic              rd_release,
   input  logic              rd_bank,
   output logic [1:0]        bank_full,
   output logic              overflow,
   output logic              short_line,
   input  logic              clear_flags
);

   localparam int BANK_W = ADDR_W - 1;
   localparam int WCW    = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
   localparam logic [WCW-1:0] LAST_WORD = WCW'(LINE_WORDS - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DROP = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic            wr_bank;
   logic [WCW-1:0]  word_cnt;
   logic [1:0]      pix_cnt;
   logic [47:0]     pack;        // lanes 0..2; lane 3 comes straight from pix_data
   logic            done_pend;   // last word written this cycle, announce next cycle
   logic            done_bank;

   logic            sol;
   logic            target_full;
   logic            start_fill;
   logic            start_drop;
   logic            abort;
   logic            accept;
   logic            word_end;
   logic            line_end;
   logic [1:0]      rel_mask;
   logic [1:0]      set_mask;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A start of line is evaluated identically in every state; in FILL it also
   // abandons the partial line. A same-cycle release counts as freeing the bank.
   always_comb begin
      state_nxt   = state;
      start_fill  = 1'b0;
      start_drop  = 1'b0;
      abort       = 1'b0;
      accept      = 1'b0;
      word_end    = 1'b0;
      line_end    = 1'b0;
      sol         = pix_valid & pix_sol;
      target_full = bank_full[wr_bank] & ~(rd_release & (rd_bank == wr_bank));
      if (sol) begin
         abort = (state == FILL);
         if (!enable) begin
            state_nxt = IDLE;
         end else if (target_full) begin
            state_nxt  = DROP;
            start_drop = 1'b1;
         end else begin
            state_nxt  = FILL;
            start_fill = 1'b1;
         end
      end else if ((state == FILL) && pix_valid) begin
         accept = 1'b1;
         if (pix_cnt == 2'd3) begin
            word_end = 1'b1;
            if (word_cnt == LAST_WORD) begin
               line_end  = 1'b1;
               state_nxt = IDLE;
            end
         end
      end
   end

   always_comb begin
      rel_mask = 2'b00;
      set_mask = 2'b00;
      if (rd_release) begin
         rel_mask = rd_bank ? 2'b10 : 2'b01;
      end
      if (done_pend) begin
         set_mask = done_bank ? 2'b10 : 2'b01;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_address    <= '0;
         mem_writedata  <= '0;
         mem_byteenable <= 8'h00;
         mem_chipselect <= 1'b0;
         mem_write      <= 1'b0;
         line_ready     <= 1'b0;
         line_bank      <= 1'b0;
         bank_full      <= 2'b00;
         overflow       <= 1'b0;
         short_line     <= 1'b0;
         wr_bank        <= 1'b0;
         word_cnt       <= '0;
         pix_cnt        <= 2'd0;
         pack           <= '0;
         done_pend      <= 1'b0;
         done_bank      <= 1'b0;
      end else begin
         mem_write      <= word_end;
         mem_chipselect <= word_end;
         mem_byteenable <= word_end ? 8'hFF : 8'h00;
         if (word_end) begin
            mem_address   <= {wr_bank, BANK_W'(word_cnt)};
            mem_writedata <= {pix_data, pack};
         end

         if (start_fill) begin
            pack[15:0] <= pix_data;
            pix_cnt    <= 2'd1;
            word_cnt   <= '0;
         end else if (accept) begin
            case (pix_cnt)
               2'd0:    pack[15:0]  <= pix_data;
               2'd1:    pack[31:16] <= pix_data;
               2'd2:    pack[47:32] <= pix_data;
               default: ;
            endcase
            pix_cnt <= pix_cnt + 2'd1;
            if (word_end) begin
               word_cnt <= line_end ? '0 : word_cnt + WCW'(1);
            end
         end

         // wr_bank flips as soon as the last word is accepted so a start of
         // line in the very next cycle already targets the other bank.
         done_pend <= line_end;
         if (line_end) begin
            done_bank <= wr_bank;
            wr_bank   <= ~wr_bank;
         end

         line_ready <= done_pend;
         if (done_pend) begin
            line_bank <= done_bank;
         end
         bank_full <= (bank_full & ~rel_mask) | set_mask;

         overflow   <= start_drop | (overflow & ~clear_flags);
         short_line <= abort | (short_line & ~clear_flags);
      end
   end

endmodule

// File: tb/tb_bram_line_writer.sv
// tb/tb_bram_line_writer.sv - scoreboard bench for bram_line_writer with a line-level reference model

module tb_bram_line_writer;

   localparam int ADDR_W     = 10;
   localparam int LW         = 4;
   localparam int BANK_WORDS = 1 << (ADDR_W - 1);

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              pix_valid = 1'b0;
   logic              pix_sol = 1'b0;
   logic [15:0]       pix_data = '0;
   logic [ADDR_W-1:0] mem_address;
   logic [63:0]       mem_writedata;
   logic [7:0]        mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic              line_ready;
   logic              line_bank;
   logic              rd_release = 1'b0;
   logic              rd_bank = 1'b0;
   logic [1:0]        bank_full;
   logic              overflow;
   logic              short_line;
   logic              clear_flags = 1'b0;

   bram_line_writer #(.ADDR_W(ADDR_W), .LINE_WORDS(LW)) dut (
      .clk(clk), .reset(reset), .enable(enable),
      .pix_valid(pix_valid), .pix_sol(pix_sol), .pix_data(pix_data),
      .mem_address(mem_address), .mem_writedata(mem_writedata),
      .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
      .mem_write(mem_write), .line_ready(line_ready), .line_bank(line_bank),
      .rd_release(rd_release), .rd_bank(rd_bank), .bank_full(bank_full),
      .overflow(overflow), .short_line(short_line), .clear_flags(clear_flags)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct { int addr; logic [63:0] data; int at; } wr_t;
   typedef struct { int bank; int at; } lr_t;
   wr_t exp_wr[$];
   lr_t exp_lr[$];

   // Line-level reference model
   bit          m_in_line;
   int          m_bank;
   bit [1:0]    m_full;
   bit          m_ovf;
   bit          m_short;
   int          m_word;
   logic [15:0] m_pix[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_in_line = 0; m_bank = 0; m_full = 2'b00; m_ovf = 0; m_short = 0; m_word = 0;
      m_pix.delete();
   endtask

   task automatic model_step(input bit v, input bit s, input logic [15:0] d,
                             input bit en, input bit rel, input bit rb, input bit clr);
      logic [63:0] w;
      if (clr) begin m_ovf = 0; m_short = 0; end
      if (rel) m_full[rb] = 1'b0;
      if (v && s) begin
         if (m_in_line) m_short = 1;
         m_in_line = 0;
         m_pix.delete();
         if (en) begin
            if (m_full[m_bank]) m_ovf = 1;
            else begin
               m_in_line = 1;
               m_word = 0;
               m_pix.push_back(d);
            end
         end
      end else if (v && m_in_line) begin
         m_pix.push_back(d);
         if (m_pix.size() == 4) begin
            w = 64'd0;
            for (int k = 0; k < 4; k++) w = w | (64'(m_pix[k]) << (16 * k));
            exp_wr.push_back('{m_bank * BANK_WORDS + m_word, w, cyc + 1});
            m_pix.delete();
            m_word++;
            if (m_word == LW) begin
               exp_lr.push_back('{m_bank, cyc + 2});
               m_full[m_bank] = 1'b1;
               m_bank = 1 - m_bank;
               m_in_line = 0;
            end
         end
      end
   endtask

   task automatic drive(input bit v, input bit s, input logic [15:0] d,
                        input bit en, input bit rel, input bit rb, input bit clr);
      pix_valid = v; pix_sol = s; pix_data = d; enable = en;
      rd_release = rel; rd_bank = rb; clear_flags = clr;
      model_step(v, s, d, en, rel, rb, clr);
      @(posedge clk); #1;
      pix_valid = 0; pix_sol = 0; rd_release = 0; clear_flags = 0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 16'h0, enable, 0, 0, 0);
   endtask

   task automatic send_line(input int n, input logic [15:0] base, input bit en);
      for (int i = 0; i < n; i++) drive(1, i == 0, base + 16'(i), en, 0, 0, 0);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_bank_full"}, bank_full, m_full);
      check({tag, "_overflow"}, overflow, m_ovf);
      check({tag, "_short_line"}, short_line, m_short);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mem_write"}, mem_write, 0);
      check({tag, "_mem_chipselect"}, mem_chipselect, 0);
      check({tag, "_mem_byteenable"}, mem_byteenable, 8'h00);
      check({tag, "_mem_address"}, mem_address, 0);
      check({tag, "_mem_writedata"}, mem_writedata, 64'h0);
      check({tag, "_line_ready"}, line_ready, 0);
      check({tag, "_line_bank"}, line_bank, 0);
      check({tag, "_bank_full"}, bank_full, 2'b00);
      check({tag, "_overflow"}, overflow, 0);
      check({tag, "_short_line"}, short_line, 0);
   endtask

   // Monitor: pops expected writes and line-ready pulses as the DUT presents them
   always @(negedge clk) begin
      if (!reset) begin
         if (mem_write) begin
            check("write_byteenable", mem_byteenable, 8'hFF);
            check("write_chipselect", mem_chipselect, 1);
            if (exp_wr.size() == 0) begin
               check("unexpected_write_addr", mem_address, 64'hFFFF_FFFF);
            end else begin
               wr_t e;
               e = exp_wr.pop_front();
               check("write_addr", mem_address, e.addr);
               check("write_data", mem_writedata, e.data);
               check("write_cycle", cyc, e.at);
            end
         end else begin
            check("idle_byteenable", mem_byteenable, 8'h00);
         end
         if (line_ready) begin
            if (exp_lr.size() == 0) begin
               check("unexpected_line_ready", line_ready, 0);
            end else begin
               lr_t e;
               e = exp_lr.pop_front();
               check("line_bank", line_bank, e.bank);
               check("line_ready_cycle", cyc, e.at);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      reset = 0;
      idle(2);

      // Two lines fill both banks
      send_line(16, 16'h0001, 1);
      idle(3);
      check_status("line1");
      send_line(16, 16'h0100, 1);
      idle(3);
      check_status("line2");
      check("line2_line_bank_held", line_bank, 1);

      // Both banks full: dropped; clear_flags in the same cycle loses to the set
      drive(1, 1, 16'h0200, 1, 0, 0, 1);
      for (int i = 1; i < 16; i++) drive(1, 0, 16'h0200 + 16'(i), 1, 0, 0, 0);
      idle(3);
      check_status("drop");
      // Release bank 0 together with the next sol
      drive(1, 1, 16'h0300, 1, 1, 0, 0);
      for (int i = 1; i < 16; i++) drive(1, 0, 16'h0300 + 16'(i), 1, 0, 0, 0);
      idle(3);
      check_status("release_sol");
      drive(0, 0, 0, 1, 1, 0, 0);
      drive(0, 0, 0, 1, 1, 1, 1);
      idle(2);
      check_status("released");

      // Short line: sol after 6 pixels, restart in the same bank
      send_line(6, 16'h0400, 1);
      send_line(16, 16'h0500, 1);
      idle(3);
      check_status("short");
      drive(0, 0, 0, 1, 1, 1, 1);
      idle(2);

      // enable low at sol, then enable dropped mid-line
      send_line(16, 16'h0600, 0);
      idle(2);
      drive(1, 1, 16'h0700, 1, 0, 0, 0);
      drive(1, 0, 16'h0701, 1, 0, 0, 0);
      for (int i = 2; i < 16; i++) drive(1, 0, 16'h0700 + 16'(i), 0, 0, 0, 0);
      idle(3);
      check_status("enable");
      drive(0, 0, 0, 1, 1, 0, 0);
      idle(2);

      // Reset during word 2 of a line
      send_line(9, 16'h0800, 1);
      reset = 1;
      model_reset();
      idle(2);
      check_all_zero("midline_reset");
      check("reset_pending_writes", exp_wr.size(), 0);
      reset = 0;
      idle(2);
      send_line(16, 16'h0900, 1);
      idle(3);
      check_status("after_reset");

      // Randomized lines
      for (int ln = 0; ln < 60; ln++) begin
         bit en;
         int n;
         logic [15:0] d;
         en = ($urandom_range(0, 5) != 0);
         n  = ($urandom_range(0, 2) != 0) ? 16 : $urandom_range(1, 15);
         d  = 16'($urandom);
         drive(1, 1, d, en, $urandom_range(0, 2) == 0, 1'($urandom), 0);
         for (int i = 1; i < n; i++) begin
            while ($urandom_range(0, 3) == 0)
               drive(0, 1'($urandom), 16'($urandom), 1'($urandom), 0, 0, 0);
            drive(1, 0, 16'($urandom), 1'($urandom), 0, 0, 0);
         end
         idle(2);
         for (int g = $urandom_range(0, 3); g > 0; g--)
            drive(0, 0, 0, enable, $urandom_range(0, 1), 1'($urandom), $urandom_range(0, 4) == 0);
         idle(1);
         if (ln % 4 == 3) check_status("random");
      end

      idle(5);
      check("final_writes_drained", exp_wr.size(), 0);
      check("final_line_ready_drained", exp_lr.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
